// File: rtl/dma_desc_sched.sv
// Descriptor FIFO and issue sequencer for the DMA control FSM. It issues one queued
// descriptor at a time, tracks completions and keeps a sticky error flag.
module dma_desc_sched #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LEN_W        = 32,
  parameter int unsigned CNT_W        = 16,
  parameter bit          ABORT_ON_ERR = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [ADDR_W-1:0]          push_src_addr_i,
  input  logic [ADDR_W-1:0]          push_dst_addr_i,
  input  logic [LEN_W-1:0]           push_num_bytes_i,
  output logic                       dma_go_o,
  output logic [ADDR_W-1:0]          dma_src_addr_o,
  output logic [ADDR_W-1:0]          dma_dst_addr_o,
  output logic [LEN_W-1:0]           dma_num_bytes_o,
  input  logic                       dma_done_i,
  input  logic                       dma_error_i,
  input  logic                       clear_dma_i,
  input  logic                       err_clr_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
  output logic [CNT_W-1:0]           done_cnt_o,
  output logic                       err_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StClear, StHalt} state_e;

  state_e            state_q, state_d;
  logic              go_q;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  done_cnt_q;
  logic              done_inc;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q;

  logic [ADDR_W-1:0] src_mem [DEPTH];
  logic [ADDR_W-1:0] dst_mem [DEPTH];
  logic [LEN_W-1:0]  len_mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic push, pop, flush;

  assign push_ready_o = (count_q != CntW'(DEPTH)) && (state_q != StHalt);
  assign push         = push_valid_i && push_ready_o;
  assign pop          = (state_q == StIdle) && (count_q != '0);
  // Entering or sitting in HALT discards everything still queued.
  assign flush        = (state_d == StHalt);

  always_comb begin
    state_d  = state_q;
    done_inc = 1'b0;
    case (state_q)
      StIdle: begin
        if (pop) begin
          if (len_mem[rd_ptr_q] != '0) state_d = StRun;
          else                         done_inc = 1'b1;
        end
      end
      StRun: begin
        if (dma_done_i) state_d = StClear;
      end
      StClear: begin
        if (clear_dma_i) begin
          done_inc = 1'b1;
          state_d  = (ABORT_ON_ERR && (err_q || dma_error_i)) ? StHalt : StIdle;
        end
      end
      StHalt: begin
        if (err_clr_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (dma_error_i)    err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      go_q       <= 1'b0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= (state_d == StRun);
      err_q   <= err_d;
      if (done_inc) done_cnt_q <= done_cnt_q + CNT_W'(1);
      if (pop) begin
        src_q <= src_mem[rd_ptr_q];
        dst_q <= dst_mem[rd_ptr_q];
        len_q <= len_mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr_q] <= push_src_addr_i;
      dst_mem[wr_ptr_q] <= push_dst_addr_i;
      len_mem[wr_ptr_q] <= push_num_bytes_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dma_go_o        = go_q;
  assign dma_src_addr_o  = src_q;
  assign dma_dst_addr_o  = dst_q;
  assign dma_num_bytes_o = len_q;
  assign busy_o          = (state_q != StIdle) || (count_q != '0);
  assign fifo_count_o    = count_q;
  assign done_cnt_o      = done_cnt_q;
  assign err_o           = err_q;

endmodule
